// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional feature macro: FETCH_PERF_EN (see fetch_sequencer.sv).
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [XLEN-1:0] DEF_HANDLER_PC = 32'h0000_4180;
    localparam logic [XLEN-1:0] DEF_IM_BASE    = 32'h0000_3000;
    localparam logic [XLEN-1:0] DEF_IM_LIMIT   = 32'h0000_6FFC;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} fetch_state_e;

    typedef enum logic [1:0] {NONE, BR, ERET, EXC} redir_cause_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_slot_t;

    // Word-aligned and inside the instruction-memory window.
    function automatic logic fetch_addr_ok(input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] lo,
                                           input logic [XLEN-1:0] hi);
        return (a[1:0] == 2'b00) && (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding slot for responses that arrive while IF/ID is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        flush_i,
    input  fetch_slot_t slot_i,
    output fetch_slot_t slot_o,
    output logic        full_o
);

    logic        full_q, full_d;
    fetch_slot_t slot_q, slot_d;

    // Flush wins over load, load wins over drain.
    always_comb begin
        full_d = full_q;
        slot_d = slot_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            slot_d = slot_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    // Slot register.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            slot_q <= '0;
        end else begin
            full_q <= full_d;
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;
    assign full_o = full_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches over req/ready, feeds IF/ID,
// and applies branch (with delay slot), exception and eret redirects.
// Optional feature macro: FETCH_PERF_EN adds perf_fetches / perf_bubbles counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [XLEN-1:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter logic [XLEN-1:0] IM_BASE    = DEF_IM_BASE,
    parameter logic [XLEN-1:0] IM_LIMIT   = DEF_IM_LIMIT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            exc_req,
    input  logic            eret_req,
    input  logic [XLEN-1:0] epc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_adel
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetches,
    output logic [XLEN-1:0] perf_bubbles
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drain_addr_q, drain_addr_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic            if_adel_q, if_adel_d;

    logic            addr_ok;
    logic            accept;
    logic            fetch_accept;
    logic            skid_full, skid_load, skid_drain, skid_flush;
    fetch_slot_t     skid_slot;
    redir_cause_e    cause;

    assign addr_ok      = fetch_addr_ok(pc_q, IM_BASE, IM_LIMIT);
    assign imem_req     = ((state_q == REQ) && addr_ok && !skid_full) || (state_q == DRAIN);
    assign imem_addr    = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign accept       = imem_req && imem_ready;
    assign fetch_accept = accept && (state_q == REQ);

    fetch_skid_buf u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .flush_i (skid_flush),
        .slot_i  ('{pc: pc_q, instr: imem_rdata}),
        .slot_o  (skid_slot),
        .full_o  (skid_full)
    );

    // Redirect arbitration: exception, then eret, then an unstalled branch.
    always_comb begin
        cause = NONE;
        if (exc_req)                  cause = EXC;
        else if (eret_req)            cause = ERET;
        else if (br_taken && !stall)  cause = BR;
    end

    // Next-state, PC and IF/ID slot.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        pend_d       = pend_q;
        pend_tgt_d   = pend_tgt_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        if_adel_d    = if_adel_q;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_flush   = 1'b0;

        if ((cause == EXC) || (cause == ERET)) begin
            skid_flush = 1'b1;
            pend_d     = 1'b0;
            if_valid_d = 1'b0;
            if_adel_d  = 1'b0;
            pc_d       = (cause == EXC) ? HANDLER_PC : epc;
            if (imem_req && !imem_ready) begin
                state_d      = DRAIN;
                drain_addr_d = imem_addr;
            end else begin
                state_d = IDLE;
            end
        end else begin
            // IF/ID slot: skid first, then a fresh response, then a fault slot.
            if (!stall) begin
                if (skid_full) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = skid_slot.pc;
                    if_instr_d = skid_slot.instr;
                    if_adel_d  = 1'b0;
                    skid_drain = 1'b1;
                end else if (fetch_accept) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = imem_rdata;
                    if_adel_d  = 1'b0;
                end else if ((state_q == REQ) && !addr_ok) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = '0;
                    if_adel_d  = 1'b1;
                    state_d    = HALT;
                end else begin
                    if_valid_d = 1'b0;
                end
            end else if (fetch_accept) begin
                skid_load = 1'b1;
            end

            // PC advance; the response accepted after a branch is its delay slot.
            if (fetch_accept) begin
                if (pend_q) begin
                    pc_d   = pend_tgt_q;
                    pend_d = 1'b0;
                end else if (cause == BR) begin
                    pc_d = br_target;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end

            // A new branch whose delay slot is not fetched yet is remembered.
            if ((cause == BR) && !pend_q) begin
                if (skid_full) begin
                    pc_d = br_target;
                end else if (!fetch_accept) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = br_target;
                end
            end

            case (state_q)
                IDLE:    state_d = REQ;
                DRAIN:   if (imem_ready) state_d = REQ;
                default: ;
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            pend_q       <= 1'b0;
            pend_tgt_q   <= '0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= RESET_PC;
            if_instr_q   <= '0;
            if_adel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            pend_q       <= pend_d;
            pend_tgt_q   <= pend_tgt_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            if_adel_q    <= if_adel_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;
    assign if_adel  = if_adel_q;

    // A second branch before the first one's delay slot is a protocol error.
    br_overlap_a: assert property (@(posedge clk) disable iff (reset)
        !(br_taken && !stall && !exc_req && !eret_req && pend_q));

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] perf_fetches_q, perf_bubbles_q;

    // Accepted-response and unstalled-bubble counters, free-running with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetches_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (accept)                 perf_fetches_q <= perf_fetches_q + 32'd1;
            if (!if_valid_q && !stall)  perf_bubbles_q <= perf_bubbles_q + 32'd1;
        end
    end

    assign perf_fetches = perf_fetches_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, redirect
// sequences, and a randomized run checked against a stream-level model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_adel;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetches;
    logic [31:0] perf_bubbles;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    assign imem_rdata = instr_of(imem_addr);

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc        (epc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_adel    (if_adel)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetches (perf_fetches),
        .perf_bubbles (perf_bubbles)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic        req_prev;
    logic [31:0] col_pc    [8];
    logic [31:0] col_instr [8];
    logic        col_adel  [8];
    int          watch_hits;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NVEC  = 15;
    localparam int EXP_N = 2048;

    vec_t        vt [NVEC];
    logic [31:0] exp_pc [EXP_N];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, expv);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, expv);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic b, input logic [31:0] t,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.ready = r; v.br = b; v.tgt = t;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    task automatic idle_inputs();
        stall = 1'b0; br_taken = 1'b0; br_target = '0;
        exc_req = 1'b0; eret_req = 1'b0; epc = '0; imem_ready = 1'b0;
        req_prev = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk1("rst_imem_req", imem_req, 1'b0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk ("rst_if_pc",    if_pc,    32'h0000_3000);
        chk ("rst_if_instr", if_instr, 32'h0);
        chk1("rst_if_adel",  if_adel,  1'b0);
        reset = 1'b0;
    endtask

    // Memory answering one cycle after each request is raised.
    task automatic mem_step();
        imem_ready = imem_req && req_prev && !imem_ready;
        req_prev   = imem_req;
    endtask

    task automatic run_until_req(input logic [31:0] addr, input int budget, input string name);
        bit hit = 0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == addr) begin
                hit = 1;
                imem_ready = 1'b0;
                req_prev   = 1'b1;
            end else begin
                mem_step();
            end
        end
        if (!hit) timeout(name);
    endtask

    task automatic run_until_deliver(input logic [31:0] pc, input int budget, input string name);
        bit hit = 0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            if (if_valid && if_pc == pc) begin
                hit = 1;
                imem_ready = 1'b0;
                req_prev   = imem_req;
            end else begin
                mem_step();
            end
        end
        if (!hit) timeout(name);
    endtask

    task automatic collect(input int n, input int budget, input logic [31:0] watch,
                           input string name, output int got);
        got = 0;
        watch_hits = 0;
        stall = 1'b0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == watch) watch_hits++;
            if (if_valid) begin
                col_pc[got]    = if_pc;
                col_instr[got] = if_instr;
                col_adel[got]  = if_adel;
                got++;
            end
            mem_step();
        end
        if (got < n) timeout(name);
    endtask

    task automatic expect_slot(input string name, input int idx, input int got,
                               input logic [31:0] pc, input logic adel);
        if (idx < got) begin
            chk ({name, "_pc"},    col_pc[idx],    pc);
            chk ({name, "_instr"}, col_instr[idx], adel ? 32'h0 : instr_of(pc));
            chk1({name, "_adel"},  col_adel[idx],  adel);
        end
    endtask

    task automatic adel_case(input logic [31:0] bad, input string name);
        int got;
        int reqs;
        do_reset();
        run_until_deliver(32'h3000, 20, {name, "_start"});
        eret_req = 1'b1;
        epc      = bad;
        @(negedge clk);
        eret_req = 1'b0;
        mem_step();
        collect(1, 10, bad, {name, "_slot"}, got);
        expect_slot(name, 0, got, bad, 1'b1);
        chk({name, "_noreq"}, 32'(watch_hits), 32'd0);
        reqs = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (imem_req) reqs++;
        end
        chk ({name, "_halt_reqs"},  32'(reqs), 32'd0);
        chk1({name, "_halt_valid"}, if_valid, 1'b0);
        exc_req = 1'b1;
        @(negedge clk);
        exc_req = 1'b0;
        collect(1, 10, 32'hFFFF_FFFF, {name, "_resume"}, got);
        expect_slot({name, "_resume"}, 0, got, 32'h4180, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          got;
        int          d, a, pend_idx;
        bit          pend, prev_wait;
        logic [31:0] prev_addr, tgt;

        // stall ready br tgt | req addr valid pc
        vt[0]  = mk(0, 0, 0, 32'h0,    1, 32'h3000, 0, 32'h0);
        vt[1]  = mk(0, 1, 0, 32'h0,    1, 32'h3000, 0, 32'h0);
        vt[2]  = mk(0, 0, 0, 32'h0,    1, 32'h3004, 1, 32'h3000);
        vt[3]  = mk(0, 1, 0, 32'h0,    1, 32'h3004, 0, 32'h0);
        vt[4]  = mk(0, 0, 1, 32'h3100, 1, 32'h3008, 1, 32'h3004);
        vt[5]  = mk(0, 1, 0, 32'h0,    1, 32'h3008, 0, 32'h0);
        vt[6]  = mk(0, 0, 0, 32'h0,    1, 32'h3100, 1, 32'h3008);
        vt[7]  = mk(0, 1, 0, 32'h0,    1, 32'h3100, 0, 32'h0);
        vt[8]  = mk(1, 1, 0, 32'h0,    1, 32'h3104, 1, 32'h3100);
        vt[9]  = mk(1, 0, 0, 32'h0,    0, 32'h0,    1, 32'h3100);
        vt[10] = mk(1, 0, 0, 32'h0,    0, 32'h0,    1, 32'h3100);
        vt[11] = mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 32'h3100);
        vt[12] = mk(0, 0, 0, 32'h0,    1, 32'h3108, 1, 32'h3104);
        vt[13] = mk(0, 1, 0, 32'h0,    1, 32'h3108, 0, 32'h0);
        vt[14] = mk(0, 0, 0, 32'h0,    1, 32'h310C, 1, 32'h3108);

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            chk1($sformatf("vec%0d_req", i), imem_req, vt[i].e_req);
            if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
            chk1($sformatf("vec%0d_valid", i), if_valid, vt[i].e_valid);
            if (vt[i].e_valid) begin
                chk ($sformatf("vec%0d_pc", i),    if_pc,    vt[i].e_pc);
                chk ($sformatf("vec%0d_instr", i), if_instr, instr_of(vt[i].e_pc));
                chk1($sformatf("vec%0d_adel", i),  if_adel,  1'b0);
            end
            stall      = vt[i].stall;
            imem_ready = vt[i].ready;
            br_taken   = vt[i].br;
            br_target  = vt[i].tgt;
        end

        // Exception under stall while 0x3010 is outstanding.
        do_reset();
        run_until_req(32'h3010, 40, "exc_reach");
        exc_req = 1'b1;
        stall   = 1'b1;
        @(negedge clk);
        exc_req = 1'b0;
        chk1("exc_drain_req",   imem_req,  1'b1);
        chk ("exc_drain_addr",  imem_addr, 32'h3010);
        chk1("exc_drain_valid", if_valid,  1'b0);
        imem_ready = 1'b1;
        @(negedge clk);
        chk1("exc_new_req",   imem_req,  1'b1);
        chk ("exc_new_addr",  imem_addr, 32'h4180);
        chk1("exc_new_valid", if_valid,  1'b0);
        imem_ready = 1'b0;
        req_prev   = 1'b1;
        collect(2, 20, 32'hFFFF_FFFF, "exc_collect", got);
        expect_slot("exc_first",  0, got, 32'h4180, 1'b0);
        expect_slot("exc_second", 1, got, 32'h4184, 1'b0);

        // Eret and branch in the same cycle: eret wins, branch dropped.
        do_reset();
        run_until_deliver(32'h3008, 40, "eret_reach");
        eret_req  = 1'b1;
        epc       = 32'h3020;
        br_taken  = 1'b1;
        br_target = 32'h3100;
        @(negedge clk);
        eret_req = 1'b0;
        br_taken = 1'b0;
        chk1("eret_drain_req",   imem_req,  1'b1);
        chk ("eret_drain_addr",  imem_addr, 32'h300C);
        chk1("eret_drain_valid", if_valid,  1'b0);
        mem_step();
        collect(3, 30, 32'h3100, "eret_collect", got);
        expect_slot("eret_s0", 0, got, 32'h3020, 1'b0);
        expect_slot("eret_s1", 1, got, 32'h3024, 1'b0);
        expect_slot("eret_s2", 2, got, 32'h3028, 1'b0);
        chk("eret_no_branch_fetch", 32'(watch_hits), 32'd0);

        // Fetch-window and alignment faults.
        adel_case(32'h7000, "adel_7000");
        adel_case(32'h3002, "adel_3002");
        adel_case(32'h2FFC, "adel_2ffc");

        // Last legal word fetched normally, the next one faults.
        do_reset();
        run_until_deliver(32'h3000, 20, "lim_start");
        eret_req = 1'b1;
        epc      = 32'h6FFC;
        @(negedge clk);
        eret_req = 1'b0;
        mem_step();
        collect(2, 20, 32'h7000, "lim_collect", got);
        expect_slot("lim_last",  0, got, 32'h6FFC, 1'b0);
        expect_slot("lim_fault", 1, got, 32'h7000, 1'b1);
        chk("lim_noreq", 32'(watch_hits), 32'd0);

        // Randomized stall / latency / branch run against a stream model.
        do_reset();
        for (int i = 0; i < EXP_N; i++) exp_pc[i] = 32'h3000 + 32'(4 * i);
        d = 0; a = 0; pend = 0; pend_idx = 0; prev_wait = 0; prev_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (prev_wait) begin
                chk1("rnd_req_hold",  imem_req,  1'b1);
                chk ("rnd_addr_hold", imem_addr, prev_addr);
            end
            stall    = ($urandom_range(0, 9) < 3);
            br_taken = 1'b0;
            if (if_valid && !stall) begin
                chk ("rnd_pc",    if_pc,    exp_pc[d]);
                chk ("rnd_instr", if_instr, instr_of(exp_pc[d]));
                chk1("rnd_adel",  if_adel,  1'b0);
                if (pend && d == pend_idx) pend = 0;
                d++;
                if (!pend && $urandom_range(0, 3) == 0) begin
                    tgt       = 32'h3000 + 32'(4 * $urandom_range(0, 2047));
                    br_taken  = 1'b1;
                    br_target = tgt;
                    for (int j = d + 1; j < EXP_N; j++) exp_pc[j] = tgt + 32'(4 * (j - d - 1));
                    pend     = 1;
                    pend_idx = d;
                end
            end
            imem_ready = imem_req && ($urandom_range(0, 9) < 6);
            if (imem_req && imem_ready) begin
                chk("rnd_fetch_addr", imem_addr, exp_pc[a]);
                a++;
            end
            prev_wait = imem_req && !imem_ready;
            prev_addr = imem_addr;
        end
        chk1("rnd_progress", (d > 100), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the pipelined MIPS core. It owns the program counter and issues word fetches to instruction memory over a req/ready handshake. It delivers fetched instructions to the IF/ID boundary, honours hazard-unit stalls, and applies branch/jump (with delay slot), exception and eret redirects. It replaces the free-running PC register plus external next-PC mux.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
HANDLER_PC, 32'h0000_4180, exception/interrupt entry
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hazard unit: IF/ID must hold
br_taken  in  1  one-cycle pulse from ID, sampled only when stall=0
br_target  in  32  branch/jump target, valid with br_taken
exc_req  in  1  CP0 takes exception/interrupt
eret_req  in  1  eret retiring
epc  in  32  return address, valid with eret_req
imem_req  out  1  fetch request
imem_addr  out  32  fetch word address
imem_ready  in  1  response valid this cycle (same-cycle accept)
imem_rdata  in  32  instruction word
if_valid  out  1  if_instr/if_pc valid
if_pc  out  32  address of delivered instruction
if_instr  out  32  delivered instruction
if_adel  out  1  delivered slot is an AdEL fetch fault

Behaviour:
- Reset (synchronous, active-high; clock clk): pc=RESET_PC; state=IDLE; imem_req=0, if_valid=0, if_pc=RESET_PC, if_instr=0, if_adel=0; skid buffer empty; pending branch cleared. Reset mid-fetch abandons the outstanding request; imem shares reset and aborts too.
- States: IDLE -> REQ (next cycle after reset or redirect); REQ: imem_req=1, imem_addr=pc held stable until imem_ready=1. DRAIN: flushed request still outstanding, req held, response discarded, then REQ. HALT: faulting PC, no requests.
- Handshake: at most one outstanding request. Response accepted in cycle N appears on if_* at N+1 (registered). Back-to-back: new request issued in cycle N+1 at next pc, so best-case throughput is 1 instr/2 cycles with 1-cycle memory.
- Stall: if_* hold. A response accepted during stall goes to a 1-entry skid buffer. While the buffer is full, imem_req=0. On stall release, the buffer drains to if_* first.
- Next pc: pc+4, wrapping modulo 2^32. Pending branch: br_taken records br_target. The next instruction delivered after the pulse is the delay slot (branch+4) and passes normally; then pc <= target and the pending flag clears.
- Redirect priority: exc_req > eret_req > branch.
  - exc/eret: flush skid buffer and pending branch, if_valid<=0 next cycle, pc <= HANDLER_PC / epc.
  - State goes to DRAIN if a request is outstanding without ready this cycle, else IDLE.
  - exc/eret override stall in the same cycle.
- Address check each REQ entry: if pc[1:0]!=0 or pc<IM_BASE or pc>IM_LIMIT, no request is issued. Deliver one slot with if_valid=1, if_adel=1, if_instr=0, if_pc=pc, then HALT until exc_req/eret_req.
- A second br_taken while one is pending is ignored; this is a protocol error, and an assertion flags it.

Optional Feature:
FETCH_PERF_EN: when defined, adds output ports perf_fetches (32) and perf_bubbles (32).
- perf_fetches counts accepted responses.
- perf_bubbles counts cycles with if_valid=0 while not stall.
- Both counters clear on reset and wrap.
Undefined: ports and counters are absent.

Decomposition:
- Package fetch_pkg: RESET_PC/HANDLER_PC default constants, state enum {IDLE, REQ, DRAIN, HALT}, redirect-cause enum {NONE, BR, ERET, EXC}.
- One sub-module, fetch_skid_buf: 1-entry {pc, instr} buffer with full flag, load/drain/flush.

Test Plan:
- Reset, imem ready 1 cycle after each req -> imem_addr 0x3000, 0x3004, 0x3008; if_pc same sequence; if_adel=0.
- br_taken target 0x3100 while 0x3004 is in ID -> 0x3008 delivered (delay slot), next imem_addr 0x3100.
- stall high 3 cycles during a fetch -> if_* hold; response held in skid buffer; no imem_req while full; after release, if_pc continues in order with no loss or duplicate.
- exc_req during outstanding fetch of 0x3010, with stall=1 -> DRAIN discards response; next imem_addr 0x4180; 0x3010 never delivered.
- eret_req with epc=0x3020 plus br_taken in same cycle -> eret wins; next fetch 0x3020; branch dropped.
- Redirect to 0x7000 (and separately 0x3002) -> no imem_req; if_valid=1, if_adel=1, if_pc=0x7000, if_instr=0; then HALT until exc_req -> fetch 0x4180.
